mux_scan_capture: RTL and testbench

Scan controller for the 7-to-1 channel mux (`seventoone`: inputs i1..i7, `select[2:0]`, output `y`).
- Drives the mux `select` through the enabled channels 1..7 and waits a programmable settle time on each.
- Samples the mux output `y` and assembles the samples into a 7-bit frame.
- Hands the frame downstream with a valid/ready handshake.
- It is the stage both upstream (select source) and downstream (y consumer) of the mux.

---
 rtl/mux_scan_capture.sv | 150 +++++++++++++++
 tb/tb_mux_scan_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_capture.sv
// Scan controller for a 7-to-1 channel mux: steps select over the enabled channels,
// samples y after a settle window per channel and hands the 7-bit frame downstream.
module mux_scan_capture #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] chan_mask,
    output logic [2:0] sel,
    input  logic       y,
    output logic [6:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    localparam int unsigned NCH  = 7;
    localparam int unsigned SELW = 3;
    localparam int unsigned CW   = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]  frame_q, frame_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic [SELW-1:0] first_ch_c;
    logic [SELW-1:0] next_ch_c;

    // Lowest enabled channel of the incoming mask (0 when none).
    always_comb begin
        first_ch_c = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (chan_mask[k]) begin
                first_ch_c = SELW'(k + 1);
            end
        end
    end

    // Next higher enabled channel of the latched mask above the current one (0 when none).
    always_comb begin
        next_ch_c = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (mask_q[k] && (SELW'(k + 1) > sel_q)) begin
                next_ch_c = SELW'(k + 1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = chan_mask;
                    frame_d = '0;
                    busy_d  = 1'b1;
                    if (chan_mask != '0) begin
                        sel_d   = first_ch_c;
                        cnt_d   = CW'(1);
                        state_d = SCAN;
                    end else begin
                        sel_d   = '0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end

            SCAN: begin
                if (cnt_q == CW'(SETTLE)) begin
                    for (int k = 0; k < int'(NCH); k++) begin
                        if (sel_q == SELW'(k + 1)) begin
                            frame_d[k] = y;
                        end
                    end
                    if (next_ch_c != '0) begin
                        sel_d = next_ch_c;
                        cnt_d = CW'(1);
                    end else begin
                        sel_d   = '0;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            HOLD: begin
                if (frame_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sel         = sel_q;
    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Self-checking bench for mux_scan_capture: three builds (SETTLE 2, 1, 15), each driving
// its own behavioural 7-to-1 mux; vector table, reset sequence and randomized scans.
module tb_mux_scan_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [3];
    logic [6:0] mask_v  [3];
    logic [6:0] iv_v    [3];
    logic       ready_v [3];
    logic       y_v     [3];
    logic [2:0] sel_v   [3];
    logic [6:0] frame_v [3];
    logic       valid_v [3];
    logic       busy_v  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic mux7(input logic [6:0] iv, input logic [2:0] s);
        if (s == 3'd0) return 1'b0;
        return iv[s - 3'd1];
    endfunction

    always_comb begin
        for (int d = 0; d < 3; d++) y_v[d] = mux7(iv_v[d], sel_v[d]);
    end

    function automatic int settle_of(input int d);
        case (d)
            0: return 2;
            1: return 1;
            default: return 15;
        endcase
    endfunction

    mux_scan_capture #(.SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .chan_mask(mask_v[0]), .sel(sel_v[0]),
        .y(y_v[0]), .frame(frame_v[0]), .frame_valid(valid_v[0]), .frame_ready(ready_v[0]),
        .busy(busy_v[0]));
    mux_scan_capture #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .chan_mask(mask_v[1]), .sel(sel_v[1]),
        .y(y_v[1]), .frame(frame_v[1]), .frame_valid(valid_v[1]), .frame_ready(ready_v[1]),
        .busy(busy_v[1]));
    mux_scan_capture #(.SETTLE(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .chan_mask(mask_v[2]), .sel(sel_v[2]),
        .y(y_v[2]), .frame(frame_v[2]), .frame_valid(valid_v[2]), .frame_ready(ready_v[2]),
        .busy(busy_v[2]));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on build d; expectations derive from the channel list and settle time.
    task automatic run_scan(input int d, input logic [6:0] mask, input logic [6:0] true_iv,
                            input int rdly, input bit tog, input bit hold_start,
                            input logic [6:0] exp_frame);
        int ch[$];
        int n, s;
        s = settle_of(d);
        for (int k = 1; k <= 7; k++) if (mask[k-1]) ch.push_back(k);
        n = ch.size();

        mask_v[d]  = mask;
        iv_v[d]    = true_iv;
        start_v[d] = 1'b1;
        ready_v[d] = (rdly == 0);
        tick();
        start_v[d] = 1'b0;
        mask_v[d]  = 7'($urandom);
        chk("busy_after_start", 8'(busy_v[d]), 8'd1);
        if (n == 0) begin
            chk("zero_valid", 8'(valid_v[d]), 8'd1);
            chk("zero_sel", 8'(sel_v[d]), 8'd0);
            chk("zero_frame", 8'(frame_v[d]), 8'd0);
        end else begin
            chk("first_sel", 8'(sel_v[d]), 8'(ch[0]));
            chk("valid_early", 8'(valid_v[d]), 8'd0);
        end

        for (int e = 1; e <= n * s; e++) begin
            iv_v[d] = (tog && (e % s != 0)) ? 7'($urandom) : true_iv;
            tick();
            if (e < n * s) begin
                chk("scan_sel", 8'(sel_v[d]), 8'(ch[e / s]));
                chk("scan_valid", 8'(valid_v[d]), 8'd0);
            end else begin
                chk("end_sel", 8'(sel_v[d]), 8'd0);
                chk("end_valid", 8'(valid_v[d]), 8'd1);
                chk("end_frame", 8'(frame_v[d]), 8'(exp_frame));
            end
            chk("scan_busy", 8'(busy_v[d]), 8'd1);
        end
        iv_v[d] = true_iv;

        for (int h = 0; h < rdly; h++) begin
            start_v[d] = hold_start && (h == 2);
            tick();
            chk("hold_valid", 8'(valid_v[d]), 8'd1);
            chk("hold_frame", 8'(frame_v[d]), 8'(exp_frame));
            chk("hold_sel", 8'(sel_v[d]), 8'd0);
        end
        ready_v[d] = 1'b1;
        start_v[d] = hold_start;
        tick();
        start_v[d] = 1'b0;
        ready_v[d] = 1'b0;
        chk("hs_valid", 8'(valid_v[d]), 8'd0);
        chk("hs_busy", 8'(busy_v[d]), 8'd0);
        chk("hs_frame", 8'(frame_v[d]), 8'(exp_frame));
        tick();
        chk("idle_busy", 8'(busy_v[d]), 8'd0);
        chk("idle_valid", 8'(valid_v[d]), 8'd0);
    endtask

    typedef struct {
        int         d;
        logic [6:0] mask;
        logic [6:0] iv;
        int         rdly;
        bit         tog;
        bit         hold_start;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] rm, ri;
        bit hit;

        vecs[0] = '{0, 7'h7F, 7'h6A, 0,  1'b0, 1'b0, 7'h6A};
        vecs[1] = '{0, 7'h0A, 7'h6A, 0,  1'b0, 1'b0, 7'h0A};
        vecs[2] = '{0, 7'h00, 7'h6A, 0,  1'b0, 1'b0, 7'h00};
        vecs[3] = '{0, 7'h7F, 7'h6A, 10, 1'b0, 1'b1, 7'h6A};
        vecs[4] = '{0, 7'h55, 7'h7F, 2,  1'b1, 1'b0, 7'h55};
        vecs[5] = '{0, 7'h40, 7'h40, 1,  1'b1, 1'b0, 7'h40};
        vecs[6] = '{1, 7'h7F, 7'h6A, 0,  1'b0, 1'b0, 7'h6A};
        vecs[7] = '{1, 7'h01, 7'h7F, 3,  1'b0, 1'b1, 7'h01};
        vecs[8] = '{2, 7'h7F, 7'h6A, 0,  1'b1, 1'b0, 7'h6A};
        vecs[9] = '{2, 7'h0A, 7'h6A, 3,  1'b1, 1'b0, 7'h0A};

        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            mask_v[d]  = 7'h00;
            iv_v[d]    = 7'h00;
            ready_v[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_sel", 8'(sel_v[d]), 8'd0);
            chk("rst_frame", 8'(frame_v[d]), 8'd0);
            chk("rst_valid", 8'(valid_v[d]), 8'd0);
            chk("rst_busy", 8'(busy_v[d]), 8'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_scan(vecs[i].d, vecs[i].mask, vecs[i].iv, vecs[i].rdly, vecs[i].tog,
                     vecs[i].hold_start, vecs[i].exp);
        end

        // Reset while channel 4 is selected, then a clean rescan.
        mask_v[0]  = 7'h7F;
        iv_v[0]    = 7'h6A;
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (sel_v[0] == 3'd4) hit = 1'b1;
            else tick();
        end
        chk("reach_sel4", 8'(hit), 8'd1);
        chk("partial_frame", 8'(frame_v[0]), 8'h02);
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 8'(sel_v[0]), 8'd0);
        chk("arst_frame", 8'(frame_v[0]), 8'd0);
        chk("arst_busy", 8'(busy_v[0]), 8'd0);
        chk("arst_valid", 8'(valid_v[0]), 8'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_hold_valid", 8'(valid_v[0]), 8'd0);
        end
        rst_n = 1'b1;
        ready_v[0] = 1'b0;
        tick();
        chk("post_rst_valid", 8'(valid_v[0]), 8'd0);
        run_scan(0, 7'h7F, 7'h6A, 0, 1'b0, 1'b0, 7'h6A);

        // Randomized scans against the channel-list model.
        for (int r = 0; r < 24; r++) begin
            int dd;
            dd = (r % 4 == 3) ? 1 : 0;
            rm = 7'($urandom);
            ri = 7'($urandom);
            run_scan(dd, rm, ri, int'($urandom_range(0, 4)), 1'b1, bit'($urandom_range(0, 1)),
                     ri & rm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
